sm4_cbc_ctrl: RTL
=================

// Module: sm4_cbc_ctrl
// PURPOSE
//  Block-chaining front end placed directly upstream of the SM4 core. Loads the key into the core,
//  takes a stream of 128-bit blocks (valid/ready), applies CBC chaining (or ECB pass-through),
//  drives the core's Krdy/Drdy/EncDec strobes, and returns results on a valid/ready output stream.
// PARAMETERS
//  MODE_CBC  1   1 = CBC chaining, 0 = ECB (chain XOR bypassed, chain register unused)
//  WDOG      64  max cycles waiting for core Kvld/Dvld before abort (>=2)
// PORTS
//  CLK          in   1    clock, rising edge
//  RST          in   1    asynchronous reset, active-high
//  key_in       in   128  cipher key; captured when key_load=1 and accepted
//  key_load     in   1    key load request; accepted only in IDLE/READY
//  iv_in        in   128  initial vector; captured when iv_load=1 and accepted
//  iv_load      in   1    IV load request; accepted only in IDLE/READY
//  mode_dec     in   1    0 = encrypt, 1 = decrypt; sampled with each accepted block
//  s_valid      in   1    input block valid
//  s_ready      out  1    input ready = (state==READY) & ~key_load & ~iv_load
//  s_data       in   128  input block (plaintext for enc, ciphertext for dec)
//  m_valid      out  1    output block valid
//  m_ready      in   1    output consumer ready
//  m_data       out  128  output block
//  key_ok       out  1    round keys valid in core
//  err          out  1    sticky watchdog abort flag; cleared by an accepted key_load
//  core_EN      out  1    core enable
//  core_EncDec  out  1    to core EncDec
//  core_Kin     out  128  to core Kin (latched key)
//  core_Din     out  128  to core Din (chained block)
//  core_Krdy    out  1    one-cycle key-expansion strobe
//  core_Drdy    out  1    one-cycle data strobe
//  core_Dout    in   128  core result
//  core_Kvld    in   1    core key expansion done
//  core_Dvld    in   1    core result valid
//  core_BSY     in   1    core busy; strobes issued only when 0
// BEHAVIOUR
//  Reset: all outputs 0, chain=0, wdog=0, state=IDLE. core_EN goes 1 the first cycle after RST falls and stays 1.
//  States: IDLE, KEY_REQ, KEY_WAIT, READY, BLK_REQ, BLK_WAIT, OUT_HOLD.
//  - IDLE/READY + key_load: latch key, key_ok<=0, err<=0 -> KEY_REQ. key_load beats iv_load and s_valid.
//  - IDLE/READY + iv_load (no key_load): chain<=iv_in; stay. key_load/iv_load ignored in other states.
//  - KEY_REQ: when core_BSY=0, core_Krdy=1 for one cycle -> KEY_WAIT.
//  - KEY_WAIT: core_Kvld=1 -> key_ok<=1, READY.
//  - READY: s_valid&s_ready -> latch dec=mode_dec, blk=s_data;
//    core_Din <= dec ? s_data : s_data^chain (ECB: s_data) -> BLK_REQ. IDLE never accepts blocks.
//  - BLK_REQ: when core_BSY=0, core_Drdy=1 and core_EncDec=dec for one cycle -> BLK_WAIT.
//  - BLK_WAIT: on core_Dvld: enc: m_data<=core_Dout, chain<=core_Dout;
//    dec: m_data<=core_Dout^chain, chain<=blk (ECB: m_data<=core_Dout, chain untouched) -> OUT_HOLD.
//  - OUT_HOLD: m_valid=1; m_data stable until m_ready=1, then -> READY (m_valid 0 next cycle).
//  Latency: accept at cycle T; Drdy at T+1 if BSY=0; Dvld at D; m_valid from D+1. No block overlap.
//  core_EncDec holds the last block's value outside strobes.
//  Watchdog: counts each cycle in KEY_WAIT/BLK_WAIT, cleared on state entry. Reaching WDOG:
//    err<=1, key_ok<=0, m_valid<=0 -> IDLE. core_Kvld/core_Dvld outside the matching wait state is ignored.
//  RST mid-operation: immediate abort to reset values; in-flight block and chain lost.
// TESTING (bench instantiates real SM4 core; K=P=0123456789abcdeffedcba9876543210, C=681edf34d206965e86b3e94f536e4246)
//  1 key_load K from IDLE -> exactly one core_Krdy pulse, key_ok=1 cycle after core_Kvld, s_ready=1.
//  2 iv_load 0, enc P -> m_data=C; Drdy one cycle after accept, m_valid one cycle after Dvld.
//  3 next enc block P^C (chain=C) -> core_Din=P, m_data=C, chain=C.
//  4 iv_load 0, dec C -> P; dec C again -> P^C; key_load+s_valid same cycle -> block not taken, Krdy issued.
//  5 m_ready low 10 cycles in OUT_HOLD -> m_valid=1, m_data stable, s_ready=0; then m_ready=1 -> READY.
//  6 core stub never asserts Dvld -> err=1, key_ok=0, IDLE after WDOG cycles; RST during BLK_WAIT -> all outputs 0.

Source files
------------

// File: rtl/sm4_cbc_ctrl.sv
// CBC/ECB chaining front end for the SM4 core: key load, block chaining, core strobes.
// Latency: block accepted at T -> core_Drdy at T+1 if core idle; core_Dvld at D -> m_valid from D+1.
// Backpressure: s_ready only in READY with no load request; OUT_HOLD holds m_data until m_ready.
`timescale 1ns/1ps
module sm4_cbc_ctrl #(
    parameter int MODE_CBC = 1,
    parameter int WDOG     = 64
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [127:0] key_in,
    input  logic         key_load,
    input  logic [127:0] iv_in,
    input  logic         iv_load,
    input  logic         mode_dec,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [127:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [127:0] m_data,
    output logic         key_ok,
    output logic         err,
    output logic         core_EN,
    output logic         core_EncDec,
    output logic [127:0] core_Kin,
    output logic [127:0] core_Din,
    output logic         core_Krdy,
    output logic         core_Drdy,
    input  logic [127:0] core_Dout,
    input  logic         core_Kvld,
    input  logic         core_Dvld,
    input  logic         core_BSY
);

    localparam bit CBC = (MODE_CBC != 0);
    localparam int WW  = $clog2(WDOG);

    typedef enum logic [2:0] {
        IDLE, KEY_REQ, KEY_WAIT, READY, BLK_REQ, BLK_WAIT, OUT_HOLD
    } state_t;

    state_t         state, state_nxt;
    logic [WW-1:0]  wdog;
    logic [127:0]   chain;
    logic [127:0]   blk;
    logic           dec;
    logic           encdec_q;

    logic wdog_hit, idle_rdy, key_acc, iv_acc, blk_acc, key_done, blk_done, abort;

    assign wdog_hit = (wdog == WW'(WDOG - 1));
    assign idle_rdy = (state == IDLE) || (state == READY);
    assign key_acc  = idle_rdy & key_load;
    assign iv_acc   = idle_rdy & ~key_load & iv_load;
    assign blk_acc  = s_valid & s_ready;
    assign key_done = (state == KEY_WAIT) & core_Kvld;
    assign blk_done = (state == BLK_WAIT) & core_Dvld;
    // A result arriving on the last watchdog cycle still wins over the abort.
    assign abort    = wdog_hit & (((state == KEY_WAIT) & ~core_Kvld) |
                                  ((state == BLK_WAIT) & ~core_Dvld));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            wdog  <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                wdog <= '0;
            else if ((state == KEY_WAIT) || (state == BLK_WAIT))
                wdog <= wdog + 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        core_Krdy   = 1'b0;
        core_Drdy   = 1'b0;
        core_EncDec = encdec_q;
        case (state)
            IDLE: begin
                if (key_load) state_nxt = KEY_REQ;
            end
            READY: begin
                s_ready = ~key_load & ~iv_load;
                if (key_load)
                    state_nxt = KEY_REQ;
                else if (s_valid & ~iv_load)
                    state_nxt = BLK_REQ;
            end
            KEY_REQ: begin
                core_Krdy = ~core_BSY;
                if (!core_BSY) state_nxt = KEY_WAIT;
            end
            KEY_WAIT: begin
                if (core_Kvld)
                    state_nxt = READY;
                else if (wdog_hit)
                    state_nxt = IDLE;
            end
            BLK_REQ: begin
                core_Drdy = ~core_BSY;
                if (!core_BSY) begin
                    core_EncDec = dec;
                    state_nxt   = BLK_WAIT;
                end
            end
            BLK_WAIT: begin
                if (core_Dvld)
                    state_nxt = OUT_HOLD;
                else if (wdog_hit)
                    state_nxt = IDLE;
            end
            OUT_HOLD: begin
                m_valid = 1'b1;
                if (m_ready) state_nxt = READY;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            core_EN  <= 1'b0;
            core_Kin <= '0;
            core_Din <= '0;
            m_data   <= '0;
            chain    <= '0;
            blk      <= '0;
            dec      <= 1'b0;
            encdec_q <= 1'b0;
            key_ok   <= 1'b0;
            err      <= 1'b0;
        end else begin
            core_EN <= 1'b1;
            if (key_acc) begin
                core_Kin <= key_in;
                key_ok   <= 1'b0;
                err      <= 1'b0;
            end
            if (iv_acc && CBC)
                chain <= iv_in;
            if (key_done)
                key_ok <= 1'b1;
            if (abort) begin
                err    <= 1'b1;
                key_ok <= 1'b0;
            end
            if (blk_acc) begin
                dec      <= mode_dec;
                blk      <= s_data;
                core_Din <= (CBC && !mode_dec) ? (s_data ^ chain) : s_data;
            end
            if (core_Drdy)
                encdec_q <= dec;
            if (blk_done) begin
                if (!CBC) begin
                    m_data <= core_Dout;
                end else if (dec) begin
                    // Decrypt chains on the ciphertext that went in, not on the result.
                    m_data <= core_Dout ^ chain;
                    chain  <= blk;
                end else begin
                    m_data <= core_Dout;
                    chain  <= core_Dout;
                end
            end
        end
    end

endmodule
